// File: rtl/router_in_ctrl_if.sv
// Router ingress bus: source-side handshake (pkt_valid/data_in/busy/error) and
// destination-FIFO side (fifo_full/write_en/dout) grouped for the ingress controller.
interface router_in_ctrl_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NDEST  = 3;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic [NDEST-1:0]  fifo_full;
  logic              busy;
  logic              error;
  logic [NDEST-1:0]  write_en;
  logic [DATA_W-1:0] dout;

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, error, write_en, dout
  );

  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, error, write_en, dout
  );
endinterface

// File: rtl/router_in_ctrl.sv
// 1x3 router ingress controller: header parse, FIFO steering, parity check, back-pressure.
// Optional good/bad packet counters are built when ROUTER_IN_PKT_CNT_EN is defined.
module router_in_ctrl
`ifdef ROUTER_IN_PKT_CNT_EN
  #(parameter int unsigned CNT_W = 16)
`endif
(
  input  logic clock,
  input  logic reset,
  router_in_ctrl_if.slave bus
`ifdef ROUTER_IN_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned NDEST  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PARITY,
    S_CHECK,
    S_DROP
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] par_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              mismatch_q;
  logic              error_q;

  logic [1:0]        dest;
  logic [LEN_W-1:0]  len;
  logic              full_sel;
  logic              last_byte;
  logic              drop_done;
  logic              busy_c;
  logic              wr_c;
  logic [NDEST-1:0]  wen_c;
  logic [DATA_W-1:0] dout_c;

  assign dest      = hdr_q[1:0];
  assign len       = hdr_q[7:2];
  assign last_byte = (LEN_W'(cnt_q + LEN_W'(1)) == len);
  assign drop_done = (state_q == S_DROP) && (cnt_q == len);

  // Full flag of the latched destination; destination 3 never reaches a writing state.
  always_comb begin
    full_sel = 1'b0;
    case (dest)
      2'd0:    full_sel = bus.fifo_full[0];
      2'd1:    full_sel = bus.fifo_full[1];
      2'd2:    full_sel = bus.fifo_full[2];
      default: full_sel = 1'b0;
    endcase
  end

  // Back-pressure and write strobe; a byte is accepted in the cycle it is written.
  always_comb begin
    busy_c = 1'b0;
    wr_c   = 1'b0;
    case (state_q)
      S_HDR: begin
        busy_c = 1'b1;
        wr_c   = !full_sel;
      end
      S_PAYLOAD: begin
        busy_c = full_sel;
        wr_c   = bus.pkt_valid && !full_sel;
      end
      S_PARITY: begin
        busy_c = full_sel;
        wr_c   = !full_sel;
      end
      S_CHECK: busy_c = 1'b1;
      default: ;
    endcase
    if (reset) begin
      busy_c = 1'b0;
      wr_c   = 1'b0;
    end
  end

  assign wen_c  = wr_c ? NDEST'(3'b001 << dest) : '0;
  assign dout_c = !wr_c ? '0 : ((state_q == S_HDR) ? hdr_q : bus.data_in);

  assign bus.busy     = busy_c;
  assign bus.write_en = wen_c;
  assign bus.dout     = dout_c;
  assign bus.error    = error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      par_q      <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.pkt_valid) begin
            hdr_q   <= bus.data_in;
            par_q   <= bus.data_in;
            cnt_q   <= '0;
            error_q <= 1'b0;
            state_q <= (bus.data_in[1:0] == 2'd3) ? S_DROP : S_HDR;
          end
        end
        S_HDR: begin
          if (wr_c) state_q <= (len == '0) ? S_PARITY : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (wr_c) begin
            par_q <= par_q ^ bus.data_in;
            cnt_q <= LEN_W'(cnt_q + LEN_W'(1));
            if (last_byte) state_q <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (wr_c) begin
            mismatch_q <= (bus.data_in != par_q);
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          error_q <= mismatch_q;
          state_q <= S_IDLE;
        end
        S_DROP: begin
          // Payload bytes are counted only when qualified; the parity byte is taken unconditionally.
          if (drop_done) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (bus.pkt_valid) begin
            cnt_q <= LEN_W'(cnt_q + LEN_W'(1));
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ROUTER_IN_PKT_CNT_EN
  logic pkt_done_c;
  logic pkt_bad_c;

  assign pkt_done_c = (state_q == S_CHECK) || drop_done;
  assign pkt_bad_c  = (state_q == S_DROP) || mismatch_q;

  // Saturating per-outcome packet counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (pkt_done_c) begin
      if (pkt_bad_c) begin
        if (bad_cnt != '1) bad_cnt <= CNT_W'(bad_cnt + CNT_W'(1));
      end else begin
        if (good_cnt != '1) good_cnt <= CNT_W'(good_cnt + CNT_W'(1));
      end
    end
  end
`endif

endmodule
